// File: rtl/dsp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : dsp_ctrl_pkg
// Brief  : Shared types and helpers for the decimator cascade control logic.
// Rev    : 1.0 - initial release
// ============================================================================
package dsp_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        APPLY  = 2'd2,
        SETTLE = 2'd3
    } decim_ctrl_state_e;

    function automatic logic [5:0] popcount(input logic [31:0] value);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'b0, value[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Saturating up-counter with synchronous clear that beats increment.
// Rev    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/decim_cascade_ctrl.sv
`default_nettype none
// ============================================================================
// Module : decim_cascade_ctrl
// Brief  : Bypass-mask owner and valid gating for a cascade of decimate-by-2
//          stages; reconfigures via drain / apply / settle / resume.
// Rev    : 1.0 - initial release
// ============================================================================
module decim_cascade_ctrl #(
    parameter int                  N_STAGES     = 4,
    parameter logic [N_STAGES-1:0] RESET_MASK   = '1,
    parameter int                  DRAIN_CYCLES = 6,
    parameter int                  SETTLE_OUT   = 8,
    parameter int                  CNT_WIDTH    = 16
) (
    input  logic                              clk,
    input  logic                              arst_n,
    input  logic                              cfg_req,
    input  logic [N_STAGES-1:0]               cfg_mask,
    output logic                              cfg_ack,
    output logic                              cfg_busy,
    input  logic                              src_valid,
    output logic                              stage_valid_in,
    output logic [N_STAGES-1:0]               stage_bypass,
    input  logic                              chain_valid_out,
    output logic                              out_valid,
    output logic [$clog2(N_STAGES+1)-1:0]     ratio_log2,
    input  logic                              cnt_clr,
    output logic [CNT_WIDTH-1:0]              drop_cnt
);

    import dsp_ctrl_pkg::*;

    // DRAIN_CYCLES is expected to be at least 1.
    localparam int c_DW = $clog2(DRAIN_CYCLES + 1);
    localparam int c_SW = (SETTLE_OUT > 0) ? $clog2(SETTLE_OUT + 1) : 1;
    localparam logic [c_DW-1:0] c_DRAIN_LAST  = c_DW'(DRAIN_CYCLES - 1);
    localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'((SETTLE_OUT > 0) ? SETTLE_OUT - 1 : 0);

    decim_ctrl_state_e   r_state, w_state_nxt;
    logic [N_STAGES-1:0] r_bypass;
    logic [N_STAGES-1:0] r_mask;
    logic [c_DW-1:0]     r_drain_cnt;
    logic [c_SW-1:0]     r_settle_cnt;
    logic                r_ack;
    logic                r_busy;

    logic                w_ack_nxt;
    logic                w_start;
    logic                w_apply;
    logic                w_drop_inc;
    logic [31:0]         w_active_ext;
    logic [5:0]          w_pc;
    logic                w_unused_pc;

    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        w_start     = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            RUN: begin
                // The ack cycle itself never accepts, so a held req is not re-taken.
                if (cfg_req && !r_ack) begin
                    if (cfg_mask == r_bypass) begin
                        w_ack_nxt = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (r_drain_cnt == c_DRAIN_LAST) begin
                    w_state_nxt = APPLY;
                end
            end
            APPLY: begin
                w_apply = 1'b1;
                if (SETTLE_OUT == 0) begin
                    w_state_nxt = RUN;
                    w_ack_nxt   = 1'b1;
                end else begin
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (chain_valid_out && (r_settle_cnt == c_SETTLE_LAST)) begin
                    w_state_nxt = RUN;
                    w_ack_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= RUN;
            r_bypass     <= RESET_MASK;
            r_mask       <= RESET_MASK;
            r_drain_cnt  <= '0;
            r_settle_cnt <= '0;
            r_ack        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            if (w_start) begin
                r_mask <= cfg_mask;
                r_busy <= 1'b1;
            end else if (r_ack) begin
                r_busy <= 1'b0;
            end
            if (w_apply) begin
                r_bypass <= r_mask;
            end
            r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 1'b1 : '0;
            if (r_state != SETTLE) begin
                r_settle_cnt <= '0;
            end else if (chain_valid_out) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end
        end
    end

    assign w_drop_inc = src_valid && ((r_state == DRAIN) || (r_state == APPLY));

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_drop_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (w_drop_inc),
        .clr    (cnt_clr),
        .cnt    (drop_cnt)
    );

    always_comb begin
        w_active_ext                 = '0;
        w_active_ext[N_STAGES-1:0]   = ~r_bypass;
    end

    assign w_pc        = popcount(w_active_ext);
    assign w_unused_pc = ^w_pc;

    assign stage_valid_in = src_valid & ((r_state == RUN) | (r_state == SETTLE));
    assign out_valid      = chain_valid_out & (r_state == RUN);
    assign stage_bypass   = r_bypass;
    assign ratio_log2     = w_pc[$clog2(N_STAGES+1)-1:0];
    assign cfg_ack        = r_ack;
    assign cfg_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_decim_cascade_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_decim_cascade_ctrl
// Brief  : Directed/randomized bench for decim_cascade_ctrl with a phase-level
//          reference model (run / gated / settling).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_decim_cascade_ctrl;

    localparam int N  = 4;
    localparam int DC = 6;
    localparam int SO = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          cfg_req = 1'b0;
    logic [N-1:0]  cfg_mask = '0;
    logic          cfg_ack;
    logic          cfg_busy;
    logic          src_valid = 1'b0;
    logic          stage_valid_in;
    logic [N-1:0]  stage_bypass;
    logic          chain_valid_out = 1'b0;
    logic          out_valid;
    logic [2:0]    ratio_log2;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] drop_cnt;

    always #5 clk = ~clk;

    decim_cascade_ctrl #(
        .N_STAGES     (N),
        .RESET_MASK   (4'b1111),
        .DRAIN_CYCLES (DC),
        .SETTLE_OUT   (SO),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .cfg_req         (cfg_req),
        .cfg_mask        (cfg_mask),
        .cfg_ack         (cfg_ack),
        .cfg_busy        (cfg_busy),
        .src_valid       (src_valid),
        .stage_valid_in  (stage_valid_in),
        .stage_bypass    (stage_bypass),
        .chain_valid_out (chain_valid_out),
        .out_valid       (out_valid),
        .ratio_log2      (ratio_log2),
        .cnt_clr         (cnt_clr),
        .drop_cnt        (drop_cnt)
    );

    // Reference model: phase 0 = running, 1 = input gated, 2 = settling.
    int           m_phase;
    int           m_gate_left;
    int           m_settle_left;
    logic [N-1:0] m_bypass;
    logic [N-1:0] m_pending;
    logic         m_ack;
    logic         m_busy;
    int           m_drop;

    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           src_mode = 0;
    int           acks_seen = 0;
    bit           swap_in_settle = 0;
    logic [N-1:0] swap_mask = '0;
    bit           clr_in_gate = 0;
    bit           clr_once = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int active_stages(input logic [N-1:0] b);
        int n = 0;
        for (int i = 0; i < N; i++) if (!b[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_phase       = 0;
        m_gate_left   = 0;
        m_settle_left = 0;
        m_bypass      = 4'b1111;
        m_pending     = 4'b1111;
        m_ack         = 1'b0;
        m_busy        = 1'b0;
        m_drop        = 0;
    endtask

    task automatic check_outputs();
        chk("stage_valid_in", 32'(stage_valid_in), 32'(src_valid && (m_phase != 1)));
        chk("out_valid",      32'(out_valid),      32'(chain_valid_out && (m_phase == 0)));
        chk("stage_bypass",   32'(stage_bypass),   32'(m_bypass));
        chk("ratio_log2",     32'(ratio_log2),     32'(active_stages(m_bypass)));
        chk("cfg_ack",        32'(cfg_ack),        32'(m_ack));
        chk("cfg_busy",       32'(cfg_busy),       32'(m_busy));
        chk("drop_cnt",       32'(drop_cnt),       32'(m_drop));
    endtask

    task automatic model_step();
        logic n_ack;
        n_ack = 1'b0;
        if (cnt_clr) m_drop = 0;
        else if (src_valid && (m_phase == 1) && (m_drop < (1 << CW) - 1)) m_drop++;
        if (m_ack) m_busy = 1'b0;
        case (m_phase)
            0: if (cfg_req && !m_ack) begin
                   if (cfg_mask == m_bypass) n_ack = 1'b1;
                   else begin
                       m_phase     = 1;
                       m_gate_left = DC + 1;
                       m_busy      = 1'b1;
                       m_pending   = cfg_mask;
                   end
               end
            1: begin
                   m_gate_left--;
                   if (m_gate_left == 0) begin
                       m_bypass      = m_pending;
                       m_phase       = 2;
                       m_settle_left = SO;
                   end
               end
            default: if (chain_valid_out) begin
                   m_settle_left--;
                   if (m_settle_left == 0) begin
                       m_phase = 0;
                       n_ack   = 1'b1;
                   end
               end
        endcase
        m_ack = n_ack;
    endtask

    task automatic tick();
        case (src_mode)
            1:       src_valid = 1'b1;
            2:       src_valid = (cyc % 2 == 0);
            default: src_valid = 1'($urandom_range(0, 1));
        endcase
        chain_valid_out = 1'($urandom_range(0, 1));
        if (swap_in_settle && (m_phase == 2)) cfg_mask = swap_mask;
        cnt_clr  = clr_once || (clr_in_gate && (m_phase == 1) && (m_gate_left == 1) && src_valid);
        clr_once = 0;
        if (cnt_clr) clr_in_gate = 0;
        @(negedge clk);
        check_outputs();
        if (cfg_ack === 1'b1) acks_seen++;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic request(input logic [N-1:0] mask, output int lat);
        int start;
        start    = acks_seen;
        cfg_mask = mask;
        cfg_req  = 1'b1;
        lat      = 0;
        while ((acks_seen == start) && (lat < 300)) begin
            tick();
            lat++;
        end
        cfg_req = 1'b0;
        chk("request_completed", 32'(acks_seen != start), 32'd1);
    endtask

    initial begin
        int lat;
        int d0;
        int a0;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bypass", 32'(stage_bypass), 32'hF);
        chk("rst_ack",    32'(cfg_ack),      32'd0);
        chk("rst_busy",   32'(cfg_busy),     32'd0);
        chk("rst_drop",   32'(drop_cnt),     32'd0);
        chk("rst_ratio",  32'(ratio_log2),   32'd0);
        arst_n = 1'b1;

        // All stages bypassed, source every cycle.
        src_mode = 1;
        repeat (20) tick();
        chk("t1_ratio", 32'(ratio_log2), 32'd0);
        chk("t1_drop",  32'(drop_cnt),   32'd0);

        // Reconfigure to 1100 with source every second cycle.
        src_mode = 2;
        request(4'b1100, lat);
        chk("t2_ratio", 32'(ratio_log2), 32'd2);
        chk("t2_drop_3or4", 32'((drop_cnt == 3) || (drop_cnt == 4)), 32'd1);
        repeat (5) tick();

        // Same mask: immediate ack, no gating.
        src_mode = 0;
        d0 = int'(drop_cnt);
        request(4'b1100, lat);
        chk("t3_latency", 32'(lat), 32'd2);
        chk("t3_drop",    32'(drop_cnt), 32'(d0));
        chk("t3_busy",    32'(cfg_busy), 32'd0);

        // Request mask changes while settling; must be ignored.
        a0 = acks_seen;
        swap_mask      = 4'b0101;
        swap_in_settle = 1;
        request(4'b0011, lat);
        swap_in_settle = 0;
        repeat (6) tick();
        chk("t4_one_ack", 32'(acks_seen - a0), 32'd1);
        chk("t4_bypass",  32'(stage_bypass),   32'h3);
        request(4'b0101, lat);
        chk("t4_second",  32'(stage_bypass),   32'h5);

        // Drop counter saturation and clear priority.
        src_mode = 1;
        clr_once = 1;
        tick();
        chk("t5_clr", 32'(drop_cnt), 32'd0);
        request(4'b1111, lat);
        request(4'b0000, lat);
        chk("t5_14", 32'(drop_cnt), 32'd14);
        request(4'b1010, lat);
        chk("t5_sat", 32'(drop_cnt), 32'd15);
        clr_in_gate = 1;
        request(4'b0110, lat);
        chk("t5_clr_wins", 32'(drop_cnt), 32'd0);
        repeat (3) tick();

        // Asynchronous reset in the middle of a drain.
        cfg_mask = 4'b1001;
        cfg_req  = 1'b1;
        repeat (3) tick();
        chk("t6_busy_before", 32'(cfg_busy), 32'd1);
        arst_n = 1'b0;
        #2;
        chk("t6_bypass", 32'(stage_bypass), 32'hF);
        chk("t6_ack",    32'(cfg_ack),      32'd0);
        chk("t6_busy",   32'(cfg_busy),     32'd0);
        cfg_req = 1'b0;
        model_reset();
        #1;
        arst_n = 1'b1;
        a0 = acks_seen;
        repeat (10) tick();
        chk("t6_no_ack", 32'(acks_seen - a0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
